// File: rtl/img_sched.sv
// Capture/readout scheduler in front of the image controller: serializes commands,
// ping-pongs the two RAM blocks, validates captures and bounds each operation with a timeout.
module img_sched #(
  parameter  int unsigned ClkFreq       = 24_000_000,
  parameter  int unsigned ImgPixelCount = 4096*4096,
  parameter  int unsigned TimeoutMs     = 1000,
  localparam int unsigned PxW           = (ImgPixelCount < 1) ? 1 : $clog2(ImgPixelCount + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_capture,
  input  logic           req_skipCount,
  input  logic           req_readout,
  input  logic           rd_done,
  output logic           img_cmd_capture,
  output logic           img_cmd_readout,
  output logic           img_cmd_ramBlock,
  output logic           img_cmd_skipCount,
  input  logic           img_status_captureDone,
  input  logic [PxW-1:0] img_status_capturePixelCount,
  input  logic [17:0]    img_status_captureHighlightCount,
  input  logic [17:0]    img_status_captureShadowCount,
  output logic           busy,
  output logic           status_captureDone,
  output logic           status_captureOk,
  output logic           status_timeout,
  output logic           status_valid,
  output logic           status_validBlock,
  output logic [17:0]    status_highlightCount,
  output logic [17:0]    status_shadowCount,
  output logic           status_readoutDone,
  output logic           status_readoutRejected
);

  localparam int unsigned     TimeoutCycles = (ClkFreq / 1000) * TimeoutMs;
  localparam int unsigned     TmrW          = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [TmrW-1:0] TmrLast       = TmrW'(TimeoutCycles - 1);
  localparam logic [PxW-1:0]  PxGood        = PxW'(ImgPixelCount);

  typedef enum logic [2:0] {
    Idle,
    CapIssue,
    CapWait,
    RdIssue,
    RdWait
  } state_t;

  state_t          state, state_nx;
  logic            armed;
  logic            hist_cap, hist_rd, hist_rddone, hist_cdone;
  logic            cap_pend, cap_pend_nx;
  logic            rd_pend, rd_pend_nx;
  logic [TmrW-1:0] tmr, tmr_nx;

  logic        cmd_capture_nx, cmd_readout_nx, cmd_block_nx, cmd_skip_nx;
  logic        cap_done_nx, cap_ok_nx, timeout_nx, valid_nx, valid_blk_nx;
  logic [17:0] hl_nx, sh_nx;
  logic        rd_done_t_nx, rd_rej_nx;

  // Pulses are suppressed on the first cycle after reset while history resyncs to the inputs.
  logic cap_pls, rd_pls, rddone_pls, cdone_pls;
  assign cap_pls    = armed & (req_capture != hist_cap);
  assign rd_pls     = armed & (req_readout != hist_rd);
  assign rddone_pls = armed & (rd_done != hist_rddone);
  assign cdone_pls  = armed & (img_status_captureDone != hist_cdone);

  assign busy = (state != Idle);

  always_comb begin
    state_nx       = state;
    cap_pend_nx    = cap_pend;
    rd_pend_nx     = rd_pend;
    tmr_nx         = tmr;
    cmd_capture_nx = img_cmd_capture;
    cmd_readout_nx = img_cmd_readout;
    cmd_block_nx   = img_cmd_ramBlock;
    cmd_skip_nx    = img_cmd_skipCount;
    cap_done_nx    = status_captureDone;
    cap_ok_nx      = status_captureOk;
    timeout_nx     = status_timeout;
    valid_nx       = status_valid;
    valid_blk_nx   = status_validBlock;
    hl_nx          = status_highlightCount;
    sh_nx          = status_shadowCount;
    rd_done_t_nx   = status_readoutDone;
    rd_rej_nx      = status_readoutRejected;

    unique case (state)
      Idle: begin
        if (rd_pend) begin
          rd_pend_nx = 1'b0;
          if (!status_valid) begin
            rd_rej_nx = ~status_readoutRejected;
          end else begin
            cmd_block_nx = status_validBlock;
            state_nx     = RdIssue;
          end
        end else if (cap_pend) begin
          cap_pend_nx  = 1'b0;
          cmd_block_nx = ~status_validBlock;
          cmd_skip_nx  = req_skipCount;
          state_nx     = CapIssue;
        end
      end
      CapIssue: begin
        cmd_capture_nx = ~img_cmd_capture;
        tmr_nx         = '0;
        state_nx       = CapWait;
      end
      CapWait: begin
        if (cdone_pls) begin
          if (img_status_capturePixelCount == PxGood) begin
            valid_nx     = 1'b1;
            valid_blk_nx = img_cmd_ramBlock;
            hl_nx        = img_status_captureHighlightCount;
            sh_nx        = img_status_captureShadowCount;
          end
          cap_ok_nx   = (img_status_capturePixelCount == PxGood);
          timeout_nx  = 1'b0;
          cap_done_nx = ~status_captureDone;
          state_nx    = Idle;
        end else if (tmr == TmrLast) begin
          cap_ok_nx   = 1'b0;
          timeout_nx  = 1'b1;
          cap_done_nx = ~status_captureDone;
          state_nx    = Idle;
        end else if (tmr != '1) begin
          tmr_nx = tmr + TmrW'(1);
        end
      end
      RdIssue: begin
        cmd_readout_nx = ~img_cmd_readout;
        tmr_nx         = '0;
        state_nx       = RdWait;
      end
      RdWait: begin
        if (rddone_pls) begin
          timeout_nx   = 1'b0;
          rd_done_t_nx = ~status_readoutDone;
          state_nx     = Idle;
        end else if (tmr == TmrLast) begin
          timeout_nx   = 1'b1;
          rd_done_t_nx = ~status_readoutDone;
          state_nx     = Idle;
        end else if (tmr != '1) begin
          tmr_nx = tmr + TmrW'(1);
        end
      end
      default: state_nx = Idle;
    endcase

    // A request arriving in the same cycle Idle consumes the previous one stays pending.
    if (cap_pls) cap_pend_nx = 1'b1;
    if (rd_pls)  rd_pend_nx  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= Idle;
      armed                  <= 1'b0;
      hist_cap               <= 1'b0;
      hist_rd                <= 1'b0;
      hist_rddone            <= 1'b0;
      hist_cdone             <= 1'b0;
      cap_pend               <= 1'b0;
      rd_pend                <= 1'b0;
      tmr                    <= '0;
      img_cmd_capture        <= 1'b0;
      img_cmd_readout        <= 1'b0;
      img_cmd_ramBlock       <= 1'b0;
      img_cmd_skipCount      <= 1'b0;
      status_captureDone     <= 1'b0;
      status_captureOk       <= 1'b0;
      status_timeout         <= 1'b0;
      status_valid           <= 1'b0;
      status_validBlock      <= 1'b0;
      status_highlightCount  <= '0;
      status_shadowCount     <= '0;
      status_readoutDone     <= 1'b0;
      status_readoutRejected <= 1'b0;
    end else begin
      state                  <= state_nx;
      armed                  <= 1'b1;
      hist_cap               <= req_capture;
      hist_rd                <= req_readout;
      hist_rddone            <= rd_done;
      hist_cdone             <= img_status_captureDone;
      cap_pend               <= cap_pend_nx;
      rd_pend                <= rd_pend_nx;
      tmr                    <= tmr_nx;
      img_cmd_capture        <= cmd_capture_nx;
      img_cmd_readout        <= cmd_readout_nx;
      img_cmd_ramBlock       <= cmd_block_nx;
      img_cmd_skipCount      <= cmd_skip_nx;
      status_captureDone     <= cap_done_nx;
      status_captureOk       <= cap_ok_nx;
      status_timeout         <= timeout_nx;
      status_valid           <= valid_nx;
      status_validBlock      <= valid_blk_nx;
      status_highlightCount  <= hl_nx;
      status_shadowCount     <= sh_nx;
      status_readoutDone     <= rd_done_t_nx;
      status_readoutRejected <= rd_rej_nx;
    end
  end

endmodule

// File: tb/tb_img_sched.sv
// Directed bench for img_sched: table of capture vectors plus hand-built readout,
// reject, timeout and mid-operation reset sequences.
module tb_img_sched;

  localparam int unsigned PxW = 7;  // ImgPixelCount = 100

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_capture = 1'b0, req_skipCount = 1'b0, req_readout = 1'b0, rd_done = 1'b0;
  logic           img_cmd_capture, img_cmd_readout, img_cmd_ramBlock, img_cmd_skipCount;
  logic           img_status_captureDone = 1'b0;
  logic [PxW-1:0] img_status_capturePixelCount = '0;
  logic [17:0]    img_status_captureHighlightCount = '0, img_status_captureShadowCount = '0;
  logic           busy, status_captureDone, status_captureOk, status_timeout;
  logic           status_valid, status_validBlock, status_readoutDone, status_readoutRejected;
  logic [17:0]    status_highlightCount, status_shadowCount;

  img_sched #(
    .ClkFreq      (100_000),
    .ImgPixelCount(100),
    .TimeoutMs    (1)
  ) dut (
    .clk                             (clk),
    .rst                             (rst),
    .req_capture                     (req_capture),
    .req_skipCount                   (req_skipCount),
    .req_readout                     (req_readout),
    .rd_done                         (rd_done),
    .img_cmd_capture                 (img_cmd_capture),
    .img_cmd_readout                 (img_cmd_readout),
    .img_cmd_ramBlock                (img_cmd_ramBlock),
    .img_cmd_skipCount               (img_cmd_skipCount),
    .img_status_captureDone          (img_status_captureDone),
    .img_status_capturePixelCount    (img_status_capturePixelCount),
    .img_status_captureHighlightCount(img_status_captureHighlightCount),
    .img_status_captureShadowCount   (img_status_captureShadowCount),
    .busy                            (busy),
    .status_captureDone              (status_captureDone),
    .status_captureOk                (status_captureOk),
    .status_timeout                  (status_timeout),
    .status_valid                    (status_valid),
    .status_validBlock               (status_validBlock),
    .status_highlightCount           (status_highlightCount),
    .status_shadowCount              (status_shadowCount),
    .status_readoutDone              (status_readoutDone),
    .status_readoutRejected          (status_readoutRejected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           skip;
    logic [PxW-1:0] pix;
    logic [17:0]    hl, sh;
    logic           e_blk, e_ok, e_vblk;
    logic [17:0]    e_hl, e_sh;
  } cap_vec_t;

  cap_vec_t vecs[5];
  int n_vec = 0;
  int n_mis = 0;

  // expected toggle levels, flipped by the bench when an event is due
  logic e_cmd_cap = 1'b0, e_cmd_rd = 1'b0, e_cdone = 1'b0, e_rdone = 1'b0, e_rej = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_capture(input logic skip, input logic [PxW-1:0] pix,
                            input logic [17:0] hl, input logic [17:0] sh, input logic exp_blk);
    req_skipCount = skip;
    req_capture   = ~req_capture;
    tick();
    chk("cap_busy_n", 64'(busy), 64'(0));
    chk("cap_cmd_early", 64'(img_cmd_capture), 64'(e_cmd_cap));
    tick();
    chk("cap_busy_issue", 64'(busy), 64'(1));
    chk("cap_ramblock", 64'(img_cmd_ramBlock), 64'(exp_blk));
    chk("cap_skip", 64'(img_cmd_skipCount), 64'(skip));
    chk("cap_cmd_hold", 64'(img_cmd_capture), 64'(e_cmd_cap));
    tick();
    e_cmd_cap = ~e_cmd_cap;
    chk("cap_cmd_toggle", 64'(img_cmd_capture), 64'(e_cmd_cap));
    img_status_capturePixelCount     = pix;
    img_status_captureHighlightCount = hl;
    img_status_captureShadowCount    = sh;
    tick();
    tick();
    chk("cap_done_wait", 64'(status_captureDone), 64'(e_cdone));
    img_status_captureDone = ~img_status_captureDone;
    tick();
    e_cdone = ~e_cdone;
    chk("cap_done_toggle", 64'(status_captureDone), 64'(e_cdone));
    chk("cap_busy_done", 64'(busy), 64'(0));
    chk("cap_timeout0", 64'(status_timeout), 64'(0));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({img_cmd_capture, img_cmd_readout, img_cmd_ramBlock, img_cmd_skipCount, busy,
                status_captureDone, status_captureOk, status_timeout, status_valid,
                status_validBlock, status_highlightCount, status_shadowCount,
                status_readoutDone, status_readoutRejected});
  endfunction

  initial begin
    //         skip  pix    hl  sh  blk ok vblk e_hl e_sh
    vecs[0] = '{1'b1, 7'd100, 18'd5,  18'd7,  1'b1, 1'b1, 1'b1, 18'd5,  18'd7};
    vecs[1] = '{1'b0, 7'd100, 18'd9,  18'd3,  1'b0, 1'b1, 1'b0, 18'd9,  18'd3};
    vecs[2] = '{1'b1, 7'd99,  18'd11, 18'd13, 1'b1, 1'b0, 1'b0, 18'd9,  18'd3};
    vecs[3] = '{1'b0, 7'd100, 18'd20, 18'd30, 1'b1, 1'b1, 1'b1, 18'd20, 18'd30};
    vecs[4] = '{1'b1, 7'd101, 18'd21, 18'd31, 1'b0, 1'b0, 1'b1, 18'd20, 18'd30};

    // reset state
    #1;
    chk("reset_outputs", all_outs(), 64'(0));
    #13 rst = 1'b0;
    tick();

    // readout with no valid image is rejected
    req_readout = ~req_readout;
    tick();
    chk("rej_early", 64'(status_readoutRejected), 64'(e_rej));
    tick();
    e_rej = ~e_rej;
    chk("rej_toggle", 64'(status_readoutRejected), 64'(e_rej));
    chk("rej_busy", 64'(busy), 64'(0));
    tick();
    chk("rej_no_cmd", 64'(img_cmd_readout), 64'(e_cmd_rd));
    chk("rej_idle", 64'(busy), 64'(0));

    // ping-pong capture table
    for (int unsigned i = 0; i < 5; i++) begin
      do_capture(vecs[i].skip, vecs[i].pix, vecs[i].hl, vecs[i].sh, vecs[i].e_blk);
      chk("tbl_ok", 64'(status_captureOk), 64'(vecs[i].e_ok));
      chk("tbl_valid", 64'(status_valid), 64'(1));
      chk("tbl_vblk", 64'(status_validBlock), 64'(vecs[i].e_vblk));
      chk("tbl_hl", 64'(status_highlightCount), 64'(vecs[i].e_hl));
      chk("tbl_sh", 64'(status_shadowCount), 64'(vecs[i].e_sh));
      tick();
    end

    // readout requested during CapWait waits for the capture to finish
    req_capture = ~req_capture;
    tick();
    tick();
    chk("ovl_cap_blk", 64'(img_cmd_ramBlock), 64'(0));
    tick();
    e_cmd_cap = ~e_cmd_cap;
    chk("ovl_cap_cmd", 64'(img_cmd_capture), 64'(e_cmd_cap));
    req_readout = ~req_readout;
    tick();
    tick();
    tick();
    chk("ovl_no_rd", 64'(img_cmd_readout), 64'(e_cmd_rd));
    chk("ovl_busy", 64'(busy), 64'(1));
    img_status_capturePixelCount     = 7'd100;
    img_status_captureHighlightCount = 18'd40;
    img_status_captureShadowCount    = 18'd50;
    img_status_captureDone = ~img_status_captureDone;
    tick();
    e_cdone = ~e_cdone;
    chk("ovl_cdone", 64'(status_captureDone), 64'(e_cdone));
    chk("ovl_idle", 64'(busy), 64'(0));
    chk("ovl_vblk", 64'(status_validBlock), 64'(0));
    chk("ovl_no_rd_idle", 64'(img_cmd_readout), 64'(e_cmd_rd));
    tick();
    chk("ovl_rd_busy", 64'(busy), 64'(1));
    chk("ovl_rd_blk", 64'(img_cmd_ramBlock), 64'(0));
    chk("ovl_rd_hold", 64'(img_cmd_readout), 64'(e_cmd_rd));
    tick();
    e_cmd_rd = ~e_cmd_rd;
    chk("ovl_rd_cmd", 64'(img_cmd_readout), 64'(e_cmd_rd));
    tick();
    tick();
    chk("ovl_rdone_wait", 64'(status_readoutDone), 64'(e_rdone));
    chk("ovl_rdwait_busy", 64'(busy), 64'(1));
    rd_done = ~rd_done;
    tick();
    e_rdone = ~e_rdone;
    chk("ovl_rdone", 64'(status_readoutDone), 64'(e_rdone));
    chk("ovl_rdone_idle", 64'(busy), 64'(0));
    chk("ovl_rdone_tmo", 64'(status_timeout), 64'(0));

    // capture timeout after 100 cycles in CapWait, then a late captureDone
    req_capture = ~req_capture;
    tick();
    tick();
    chk("tmo_blk", 64'(img_cmd_ramBlock), 64'(1));
    tick();
    e_cmd_cap = ~e_cmd_cap;
    chk("tmo_cmd", 64'(img_cmd_capture), 64'(e_cmd_cap));
    repeat (99) tick();
    chk("tmo_pre_busy", 64'(busy), 64'(1));
    chk("tmo_pre_cdone", 64'(status_captureDone), 64'(e_cdone));
    chk("tmo_pre_flag", 64'(status_timeout), 64'(0));
    tick();
    e_cdone = ~e_cdone;
    chk("tmo_cdone", 64'(status_captureDone), 64'(e_cdone));
    chk("tmo_flag", 64'(status_timeout), 64'(1));
    chk("tmo_ok", 64'(status_captureOk), 64'(0));
    chk("tmo_idle", 64'(busy), 64'(0));
    chk("tmo_valid", 64'(status_valid), 64'(1));
    chk("tmo_vblk", 64'(status_validBlock), 64'(0));
    img_status_captureHighlightCount = 18'd77;
    img_status_captureDone = ~img_status_captureDone;
    tick();
    tick();
    chk("late_cdone", 64'(status_captureDone), 64'(e_cdone));
    chk("late_hl", 64'(status_highlightCount), 64'(40));
    chk("late_idle", 64'(busy), 64'(0));

    // asynchronous reset while in RdWait
    req_readout = ~req_readout;
    tick();
    tick();
    tick();
    e_cmd_rd = ~e_cmd_rd;
    chk("rst_rd_cmd", 64'(img_cmd_readout), 64'(e_cmd_rd));
    tick();
    chk("rst_rdwait_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs", all_outs(), 64'(0));
    chk("rst_async_busy", 64'(busy), 64'(0));
    #3 rst = 1'b0;
    e_cmd_cap = 1'b0; e_cmd_rd = 1'b0; e_cdone = 1'b0; e_rdone = 1'b0; e_rej = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_quiet", all_outs(), 64'(0));
    do_capture(1'b0, 7'd100, 18'd3, 18'd4, 1'b1);
    chk("post_rst_ok", 64'(status_captureOk), 64'(1));
    chk("post_rst_valid", 64'(status_valid), 64'(1));
    chk("post_rst_vblk", 64'(status_validBlock), 64'(1));
    chk("post_rst_hl", 64'(status_highlightCount), 64'(3));
    chk("post_rst_sh", 64'(status_shadowCount), 64'(4));
    chk("post_rst_no_rd", 64'(img_cmd_readout), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
